// File: rtl/bg_draw_sequencer_pkg.sv
// Shared screen geometry, colour width and sequencer state encoding for the
// background draw path.
package bg_draw_sequencer_pkg;

   localparam int unsigned SCREEN_W        = 160;
   localparam int unsigned SCREEN_H        = 120;
   localparam int unsigned SCREEN_COLOUR_W = 12;

   // Wide enough to count a DRAIN of up to ROM_LATENCY=3 extra cycles
   localparam int unsigned DRAIN_CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bg_draw_sequencer_pixel_pipe.sv
// Delay line that carries {valid, x, y} of each issued ROM address so it
// lines up with the ROM's registered read data.
module bg_draw_sequencer_pixel_pipe #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned X_W   = 8,
   parameter int unsigned Y_W   = 8
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           flush,
   input  logic           push_valid,
   input  logic [X_W-1:0] push_x,
   input  logic [Y_W-1:0] push_y,
   output logic           tap_valid,
   output logic [X_W-1:0] tap_x,
   output logic [Y_W-1:0] tap_y
);

   logic [DEPTH-1:0] valid_q;
   logic [X_W-1:0]   x_q [DEPTH];
   logic [Y_W-1:0]   y_q [DEPTH];

   // A flush kills every in-flight pixel, including the one being pushed
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= push_valid & ~flush;
         x_q[0]     <= push_x;
         y_q[0]     <= push_y;
         for (int i = 1; i < int'(DEPTH); i++) begin
            valid_q[i] <= valid_q[i-1] & ~flush;
            x_q[i]     <= x_q[i-1];
            y_q[i]     <= y_q[i-1];
         end
      end
   end

   assign tap_valid = valid_q[DEPTH-1];
   assign tap_x     = x_q[DEPTH-1];
   assign tap_y     = y_q[DEPTH-1];

endmodule

// File: rtl/bg_draw_sequencer.sv
// Full-frame raster sequencer: walks a colour ROM in raster order and replays
// each pixel as one plot strobe to the VGA adapter.
module bg_draw_sequencer
   import bg_draw_sequencer_pkg::*;
#(
   parameter int unsigned         WIDTH       = SCREEN_W,
   parameter int unsigned         HEIGHT      = SCREEN_H,
   parameter int unsigned         X_W         = 8,
   parameter int unsigned         Y_W         = 8,
   parameter int unsigned         ADDR_W      = 15,
   parameter int unsigned         COLOUR_W    = SCREEN_COLOUR_W,
   parameter int unsigned         ROM_LATENCY = 1,
   parameter int unsigned         USE_KEY     = 0,
   parameter logic [COLOUR_W-1:0] KEY_COLOUR  = '0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                abort,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   state_t                 state;
   state_t                 state_nxt;
   logic [X_W-1:0]         col;
   logic [Y_W-1:0]         row;
   logic [DRAIN_CNT_W-1:0] drain_cnt;

   logic                   col_last_c;
   logic                   last_issue_c;
   logic                   issue_c;
   logic                   flush_c;
   logic                   key_hit_c;

   logic                   tap_valid;
   logic [X_W-1:0]         tap_x;
   logic [Y_W-1:0]         tap_y;

   assign col_last_c   = (col == X_W'(WIDTH - 1));
   assign last_issue_c = col_last_c && (row == Y_W'(HEIGHT - 1));
   assign issue_c      = (state == ST_SCAN) && !abort;
   assign flush_c      = abort && ((state == ST_SCAN) || (state == ST_DRAIN));
   assign key_hit_c    = (USE_KEY != 0) && (rom_q == KEY_COLOUR);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SCAN;
         ST_SCAN: begin
            if (abort)             state_nxt = ST_IDLE;
            else if (last_issue_c) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)                                        state_nxt = ST_IDLE;
            else if (drain_cnt == DRAIN_CNT_W'(ROM_LATENCY)) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Address/counter walk; the address is bumped incrementally alongside col/row
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rom_addr  <= '0;
         col       <= '0;
         row       <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rom_addr <= '0;
                  col      <= '0;
                  row      <= '0;
               end
            end
            ST_SCAN: begin
               drain_cnt <= '0;
               if (!abort && !last_issue_c) begin
                  rom_addr <= rom_addr + ADDR_W'(1);
                  if (col_last_c) begin
                     col <= '0;
                     row <= row + Y_W'(1);
                  end else begin
                     col <= col + X_W'(1);
                  end
               end
            end
            ST_DRAIN: drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
            default: ;
         endcase
      end
   end

   bg_draw_sequencer_pixel_pipe #(
      .DEPTH (ROM_LATENCY),
      .X_W   (X_W),
      .Y_W   (Y_W)
   ) u_pixel_pipe (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush_c),
      .push_valid (issue_c),
      .push_x     (col),
      .push_y     (row),
      .tap_valid  (tap_valid),
      .tap_x      (tap_x),
      .tap_y      (tap_y)
   );

   // Adapter-facing registers; keyed pixels still move x/y but never strobe
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         plot <= tap_valid && !flush_c && !key_hit_c;
         if (tap_valid && !flush_c) begin
            x      <= tap_x;
            y      <= tap_y;
            colour <= rom_q;
         end
         busy <= (state_nxt == ST_SCAN) || (state_nxt == ST_DRAIN);
         done <= (state_nxt == ST_DONE);
      end
   end

endmodule
